// File: rtl/morse_keyer_seq_if.sv
// Character handshake bundle for the Morse keyer sequencer.
// The source drives code, unit period and abort; the keyer answers with ready.
interface morse_keyer_seq_if #(
  parameter int DIV_W = 16
);
  logic [7:0]       char_in;
  logic             char_valid;
  logic             char_ready;
  logic [DIV_W-1:0] unit_div;
  logic             abort;

  modport master (
    output char_in,
    output char_valid,
    output unit_div,
    output abort,
    input  char_ready
  );

  modport slave (
    input  char_in,
    input  char_valid,
    input  unit_div,
    input  abort,
    output char_ready
  );
endinterface

// File: rtl/morse_keyer_seq.sv
// Morse keyer sequencer: latches an encoder pattern and plays it
// as a timed key waveform with dot/dash/gap unit timing.
module morse_keyer_seq #(
  parameter int DIV_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  morse_keyer_seq_if.slave       kif,
  output logic [7:0]             enc_char,
  input  logic [7:0]             enc_morse,
  input  logic [2:0]             enc_length,
  output logic                   key_out,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = DIV_W + 2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_MARK = 3'd2;
  localparam logic [2:0] S_EGAP = 3'd3;
  localparam logic [2:0] S_CGAP = 3'd4;
  localparam logic [2:0] S_WORD = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0] unit_q, unit_d;
  logic [7:0]       pat_q, pat_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       char_q, char_d;
  logic             key_q, key_d;
  logic             done_q, done_d;

  logic [CW-1:0]    u1, u3, u4, dur;
  logic             last;

  assign u1 = {2'b00, unit_q};
  assign u3 = {1'b0, unit_q, 1'b0} + {2'b00, unit_q};
  assign u4 = {unit_q, 2'b00};

  always_comb begin
    dur = u1;
    unique case (1'b1)
      state_q == S_MARK: dur = pat_q[idx_q] ? u3 : u1;
      state_q == S_CGAP: dur = u3;
      state_q == S_WORD: dur = u4;
      default:           dur = u1;
    endcase
  end

  assign last = (cnt_q == dur - CW'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    unit_d  = unit_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    char_d  = char_q;
    key_d   = key_q;
    done_d  = 1'b0;
    unique case (1'b1)
      state_q == S_IDLE: begin
        cnt_d = '0;
        if (kif.char_valid) begin
          char_d  = kif.char_in;
          unit_d  = (kif.unit_div == '0) ? DIV_W'(1) : kif.unit_div;
          state_d = S_LOAD;
        end
      end
      state_q == S_LOAD: begin
        cnt_d   = '0;
        pat_d   = enc_morse;
        idx_d   = enc_length - 3'd1;
        key_d   = (enc_length != 3'd0);
        state_d = (enc_length == 3'd0) ? S_WORD : S_MARK;
      end
      state_q == S_MARK: begin
        if (last) begin
          cnt_d = '0;
          key_d = 1'b0;
          if (idx_q == 3'd0) begin
            state_d = S_CGAP;
          end else begin
            idx_d   = idx_q - 3'd1;
            state_d = S_EGAP;
          end
        end
      end
      state_q == S_EGAP: begin
        if (last) begin
          cnt_d   = '0;
          key_d   = 1'b1;
          state_d = S_MARK;
        end
      end
      state_q == S_CGAP,
      state_q == S_WORD: begin
        if (last) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        key_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    // Abort wins over every transition but leaves IDLE untouched.
    if (kif.abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      key_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      unit_q  <= '0;
      pat_q   <= '0;
      idx_q   <= '0;
      char_q  <= '0;
      key_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      unit_q  <= unit_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      char_q  <= char_d;
      key_q   <= key_d;
      done_q  <= done_d;
    end
  end

  assign kif.char_ready = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign enc_char       = char_q;
  assign key_out        = key_q;
  assign done           = done_q;

endmodule

// File: tb/tb_morse_keyer_seq.sv
// Bench for morse_keyer_seq: stub encoder from a dot/dash table
// and a reference waveform built from the same table.
module tb_morse_keyer_seq;

  localparam int DIV_W = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] enc_char;
  logic [7:0] enc_morse;
  logic [2:0] enc_length;
  logic       key_out;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  morse_keyer_seq_if #(.DIV_W(DIV_W)) kif ();

  morse_keyer_seq #(.DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .kif        (kif),
    .enc_char   (enc_char),
    .enc_morse  (enc_morse),
    .enc_length (enc_length),
    .key_out    (key_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string code_of(input logic [7:0] c);
    case (c)
      "A": return ".-";
      "B": return "-...";
      "C": return "-.-.";
      "D": return "-..";
      "E": return ".";
      "F": return "..-.";
      "G": return "--.";
      "H": return "....";
      "I": return "..";
      "J": return ".---";
      "K": return "-.-";
      "L": return ".-..";
      "M": return "--";
      "N": return "-.";
      "O": return "---";
      "P": return ".--.";
      "Q": return "--.-";
      "R": return ".-.";
      "S": return "...";
      "T": return "-";
      "U": return "..-";
      "V": return "...-";
      "W": return ".--";
      "X": return "-..-";
      "Y": return "-.--";
      "Z": return "--..";
      8'h01: return ".-.-.-.";
      default: return "";
    endcase
  endfunction

  function automatic logic [10:0] stub_enc(input logic [7:0] c);
    string      s;
    logic [7:0] m;
    s = code_of(c);
    m = '0;
    for (int i = 0; i < s.len(); i++)
      m = {m[6:0], (s[i] == "-")};
    // Special code sets bit7 so a 7-element pattern must ignore it.
    if (c == 8'h01) m[7] = 1'b1;
    return {3'(s.len()), m};
  endfunction

  assign {enc_length, enc_morse} = stub_enc(enc_char);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_char(input logic [7:0] c, input int u);
    string s;
    int    uu;
    int    n;
    bit    q[$];
    s  = code_of(c);
    uu = (u == 0) ? 1 : u;
    q.push_back(1'b0);
    if (s.len() == 0) begin
      for (int k = 0; k < 4 * uu; k++) q.push_back(1'b0);
    end else begin
      for (int i = 0; i < s.len(); i++) begin
        n = (s[i] == "-") ? 3 * uu : uu;
        for (int k = 0; k < n; k++) q.push_back(1'b1);
        n = (i == s.len() - 1) ? 3 * uu : uu;
        for (int k = 0; k < n; k++) q.push_back(1'b0);
      end
    end
    n_checks++;
    if (kif.char_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_before_accept char=%h got=%b exp=1", c, kif.char_ready);
    end
    kif.char_in    = c;
    kif.unit_div   = u[DIV_W-1:0];
    kif.char_valid = 1'b1;
    step();
    kif.char_valid = 1'b0;
    kif.abort      = 1'b0;
    kif.char_in    = 8'($urandom);
    kif.unit_div   = DIV_W'($urandom);
    n_checks++;
    if (enc_char !== c) begin
      n_fail++;
      $display("FAIL enc_char got=%h exp=%h", enc_char, c);
    end
    for (int i = 0; i < q.size(); i++) begin
      n_checks++;
      if (key_out !== q[i] || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL wave char=%h u=%0d cyc=%0d key=%b busy=%b done=%b exp key=%b busy=1 done=0",
                 c, u, i, key_out, busy, done, q[i]);
      end
      step();
    end
    n_checks++;
    if (done !== 1'b1 || kif.char_ready !== 1'b1 || key_out !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_cycle char=%h done=%b ready=%b key=%b busy=%b exp 1 1 0 0",
               c, done, kif.char_ready, key_out, busy);
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    kif.char_valid = 1'b0;
    kif.char_in    = '0;
    kif.unit_div   = '0;
    kif.abort      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (key_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        kif.char_ready !== 1'b1 || enc_char !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state key=%b busy=%b done=%b ready=%b enc=%h exp 0 0 0 1 00",
               key_out, busy, done, kif.char_ready, enc_char);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_dash();
    kif.char_in    = "T";
    kif.unit_div   = 16'd4;
    kif.char_valid = 1'b1;
    step();
    kif.char_valid = 1'b0;
    repeat (3) step();
    n_checks++;
    if (key_out !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_dash_key got=%b exp=1", key_out);
    end
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (key_out !== 1'b0 || busy !== 1'b0 || kif.char_ready !== 1'b1 || enc_char !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset key=%b busy=%b ready=%b enc=%h exp 0 0 1 00",
               key_out, busy, kif.char_ready, enc_char);
    end
    #12 rst_n = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (done !== 1'b0 || key_out !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset cyc=%0d done=%b key=%b busy=%b exp 0 0 0",
                 i, done, key_out, busy);
      end
      step();
    end
  endtask

  task automatic test_basic();
    run_char("E", 4);
    step();
    run_char("A", 2);
    step();
    run_char(" ", 3);
    step();
    run_char(8'h01, 1);
    step();
  endtask

  task automatic test_back_to_back();
    run_char("E", 1);
    run_char("E", 1);
    run_char("E", 0);
    run_char("E", 0);
    step();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_abort();
    kif.char_in    = "A";
    kif.unit_div   = 16'd2;
    kif.char_valid = 1'b1;
    step();
    kif.char_valid = 1'b0;
    repeat (3) step();
    n_checks++;
    if (key_out !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL egap_entry key=%b busy=%b exp 0 1", key_out, busy);
    end
    kif.abort = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b0 || key_out !== 1'b0 || done !== 1'b0 || kif.char_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort busy=%b key=%b done=%b ready=%b exp 0 0 0 1",
               busy, key_out, done, kif.char_ready);
    end
    run_char("E", 2);
    step();
    kif.char_in    = "O";
    kif.unit_div   = 16'd1;
    kif.char_valid = 1'b1;
    step();
    kif.char_valid = 1'b0;
    step();
    kif.abort = 1'b1;
    step();
    kif.abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || key_out !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_mark busy=%b key=%b exp 0 0", busy, key_out);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (done !== 1'b0 || key_out !== 1'b0) begin
        n_fail++;
        $display("FAIL post_abort cyc=%0d done=%b key=%b exp 0 0", i, done, key_out);
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [7:0] c;
    int         sel;
    for (int t = 0; t < 30; t++) begin
      sel = $urandom_range(0, 27);
      if (sel < 26)       c = 8'("A" + sel);
      else if (sel == 26) c = " ";
      else                c = 8'h01;
      run_char(c, $urandom_range(0, 3));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_gap done=%b busy=%b exp 0 0", done, busy);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_reset_mid_dash();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
